// File: rtl/lmfe_pkg.sv
// Shared LMFE constants and the SRAM arbiter decision encoding.
package lmfe_pkg;
  localparam int LMFE_AW   = 10;
  localparam int LMFE_DW   = 8;
  localparam int IMG_W     = 128;
  localparam int WIN       = 7;
  localparam int LINES_BUF = 7;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_RD   = 2'd1,
    ARB_WR   = 2'd2,
    ARB_FWR  = 2'd3
  } arb_dec_e;

  function automatic logic is_write(arb_dec_e d);
    return (d == ARB_WR) || (d == ARB_FWR);
  endfunction
endpackage

// File: rtl/lmfe_sram_arb_if.sv
// Requester-side bus of the line-buffer SRAM arbiter: buffered pixel writes and window reads.
interface lmfe_sram_arb_if
  import lmfe_pkg::*;
#(
  parameter int AW       = LMFE_AW,
  parameter int DW       = LMFE_DW,
  parameter int WF_DEPTH = 4
);
  localparam int CW = $clog2(WF_DEPTH) + 1;

  logic          wr_vld;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_rdy;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_dvld;
  logic [DW-1:0] rd_data;
  logic [CW-1:0] wf_cnt;

  modport master (
    output wr_vld, wr_addr, wr_data, rd_req, rd_addr,
    input  wr_rdy, rd_gnt, rd_dvld, rd_data, wf_cnt
  );

  modport slave (
    input  wr_vld, wr_addr, wr_data, rd_req, rd_addr,
    output wr_rdy, rd_gnt, rd_dvld, rd_data, wf_cnt
  );
endinterface

// File: rtl/lmfe_wr_fifo.sv
// Write-request FIFO: circular buffer of {addr,data} with occupancy count and
// a per-entry address match used for the read-after-write hazard check.
module lmfe_wr_fifo
  import lmfe_pkg::*;
#(
  parameter int AW    = LMFE_AW,
  parameter int DW    = LMFE_DW,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic                       push,
  input  logic [AW-1:0]              push_addr,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  input  logic [AW-1:0]              cmp_addr,
  output logic [$clog2(DEPTH):0]     cnt,
  output logic [AW-1:0]              head_addr,
  output logic [DW-1:0]              head_data,
  output logic [DEPTH-1:0]           match
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] head, tail;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail] <= push_addr;
      data_mem[tail] <= push_data;
    end
  end

  assign head_addr = addr_mem[head];
  assign head_data = data_mem[head];

  // Entry i is live when its distance from head (mod DEPTH) is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    logic [PW-1:0] off;
    assign off      = PW'(i) - head;
    assign match[i] = (CW'(off) < cnt) && (addr_mem[i] == cmp_addr);
  end
endmodule

// File: rtl/lmfe_sram_arb.sv
// Single-port arbiter for the LMFE line-buffer SRAM: read-favoured, bounded write
// starvation, read-after-write hazard guard, registered active-low SRAM controls.
module lmfe_sram_arb
  import lmfe_pkg::*;
#(
  parameter int AW         = LMFE_AW,
  parameter int DW         = LMFE_DW,
  parameter int WF_DEPTH   = 4,
  parameter int STARVE_MAX = 7
) (
  input  logic           clk,
  input  logic           RST,
  lmfe_sram_arb_if.slave bus,
  output logic [AW-1:0]  A,
  output logic [DW-1:0]  D,
  output logic           CE,
  output logic           WE,
  input  logic [DW-1:0]  Q
);
  localparam int CW = $clog2(WF_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0]       wf_cnt;
  logic [AW-1:0]       head_addr;
  logic [DW-1:0]       head_data;
  logic [WF_DEPTH-1:0] hit;
  logic                push, pop, has_wr, full, force_wr;
  logic [SW-1:0]       starve_cnt;
  logic                gnt_p1, gnt_p2;
  arb_dec_e            dec;

  assign full        = (wf_cnt == CW'(WF_DEPTH));
  assign has_wr      = (wf_cnt != '0);
  assign bus.wr_rdy  = (wf_cnt < CW'(WF_DEPTH));
  assign bus.wf_cnt  = wf_cnt;
  assign push        = bus.wr_vld & bus.wr_rdy;
  assign pop         = is_write(dec);

  lmfe_wr_fifo #(.AW(AW), .DW(DW), .DEPTH(WF_DEPTH)) u_wr_fifo (
    .clk       (clk),
    .RST       (RST),
    .push      (push),
    .push_addr (bus.wr_addr),
    .push_data (bus.wr_data),
    .pop       (pop),
    .cmp_addr  (bus.rd_addr),
    .cnt       (wf_cnt),
    .head_addr (head_addr),
    .head_data (head_data),
    .match     (hit)
  );

  assign force_wr = full || (starve_cnt == SW'(STARVE_MAX)) || (bus.rd_req && (|hit));

  always_comb begin
    dec = ARB_IDLE;
    if (has_wr && force_wr) dec = ARB_FWR;
    else if (bus.rd_req)    dec = ARB_RD;
    else if (has_wr)        dec = ARB_WR;
  end

  assign bus.rd_gnt  = (dec == ARB_RD);
  assign bus.rd_dvld = gnt_p2;
  assign bus.rd_data = Q;

  // p0: decision -> p1: SRAM pins driven -> p2: Q valid from the macro
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      A          <= '0;
      D          <= '0;
      CE         <= 1'b1;
      WE         <= 1'b1;
      gnt_p1     <= 1'b0;
      gnt_p2     <= 1'b0;
      starve_cnt <= '0;
    end else begin
      gnt_p1 <= bus.rd_gnt;
      gnt_p2 <= gnt_p1;
      case (dec)
        ARB_WR, ARB_FWR: begin
          CE <= 1'b0;
          WE <= 1'b0;
          A  <= head_addr;
          D  <= head_data;
        end
        ARB_RD: begin
          CE <= 1'b0;
          WE <= 1'b1;
          A  <= bus.rd_addr;
        end
        default: begin
          CE <= 1'b1;
          WE <= 1'b1;
        end
      endcase
      if (pop || !has_wr)
        starve_cnt <= '0;
      else if ((dec == ARB_RD) && (starve_cnt != SW'(STARVE_MAX)))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_lmfe_sram_arb.sv
// Bench for lmfe_sram_arb: random and directed traffic against a queue-based
// reference of the arbitration rules, with a scoreboard on SRAM writes and read data.
module tb_lmfe_sram_arb;
  import lmfe_pkg::*;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int WF_DEPTH = 4;
  localparam int STARVE_MAX = 7;

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { logic [DW-1:0] data; int cyc; } rd_exp_t;
  typedef struct { wr_t w; int cyc; } wr_exp_t;

  logic clk = 1'b0;
  logic RST;
  logic [AW-1:0] A;
  logic [DW-1:0] D;
  logic CE, WE;
  logic [DW-1:0] Q;

  lmfe_sram_arb_if #(.AW(AW), .DW(DW), .WF_DEPTH(WF_DEPTH)) bus ();

  lmfe_sram_arb #(.AW(AW), .DW(DW), .WF_DEPTH(WF_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk), .RST (RST), .bus (bus),
    .A (A), .D (D), .CE (CE), .WE (WE), .Q (Q)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(int a);
    return 8'(a) ^ 8'hA5;
  endfunction

  // SRAM macro model: one-cycle registered read, reloaded with a known pattern on reset.
  logic [DW-1:0] sram [1024];
  logic [DW-1:0] q_r;
  always @(posedge clk) begin
    if (RST) begin
      for (int i = 0; i < 1024; i++) sram[i] <= init_val(i);
    end else if (!CE) begin
      if (!WE) sram[A] <= D;
      else     q_r <= sram[A];
    end
  end
  assign Q = q_r;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Reference state: pending writes in arrival order and the latest pushed value per address.
  wr_t       m_q[$];
  logic [DW-1:0] ref_mem [1024];
  rd_exp_t   exp_rd[$];
  wr_exp_t   exp_wr[$];
  int        lost = 0;
  int        starve_force = 0;
  int        full_seen = 0;
  int        pp_seen = 0;

  initial begin : observer
    int sz;
    logic hz, eg, iss, psh;
    wr_t w;
    rd_exp_t re;
    wr_exp_t we;
    forever begin
      @(negedge clk);
      if (RST) begin
        m_q.delete();
        exp_rd.delete();
        exp_wr.delete();
        lost = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
      end else begin
        sz = m_q.size();
        chk("wf_cnt", 32'(bus.wf_cnt), 32'(sz));
        chk("wr_rdy", 32'(bus.wr_rdy), 32'(sz < WF_DEPTH));
        hz = 1'b0;
        foreach (m_q[i]) if (m_q[i].addr == bus.rd_addr) hz = 1'b1;
        eg = bus.rd_req && !hz && (sz < WF_DEPTH) && (lost < STARVE_MAX);
        chk("rd_gnt", 32'(bus.rd_gnt), 32'(eg));
        if (bus.rd_req && sz > 0 && lost == STARVE_MAX) starve_force++;
        if (sz == WF_DEPTH) full_seen++;
        iss = (sz > 0) && !eg;
        psh = bus.wr_vld && (sz < WF_DEPTH);
        if (psh && iss && sz == 2) pp_seen++;
        if (eg) begin
          re.data = ref_mem[bus.rd_addr];
          re.cyc  = cyc;
          exp_rd.push_back(re);
        end
        if (iss) begin
          we.w   = m_q[0];
          we.cyc = cyc;
          exp_wr.push_back(we);
          m_q.delete(0);
        end
        if (iss || sz == 0) lost = 0;
        else if (eg && lost < STARVE_MAX) lost++;
        if (psh) begin
          w.addr = bus.wr_addr;
          w.data = bus.wr_data;
          m_q.push_back(w);
          ref_mem[bus.wr_addr] = bus.wr_data;
        end
      end
    end
  end

  initial begin : monitor
    rd_exp_t re;
    wr_exp_t we;
    forever begin
      @(negedge clk);
      if (!RST) begin
        if (!CE && !WE) begin
          if (exp_wr.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sram_wr_unexpected: got write A=0x%0h D=0x%0h, expected none", A, D);
          end else begin
            we = exp_wr.pop_front();
            chk("sram_wr_addr", 32'(A), 32'(we.w.addr));
            chk("sram_wr_data", 32'(D), 32'(we.w.data));
            chk("sram_wr_latency", 32'(cyc), 32'(we.cyc + 1));
          end
        end else if (exp_wr.size() > 0 && cyc > exp_wr[0].cyc + 1) begin
          n_chk++; n_fail++;
          $display("FAIL sram_wr_missing: got no write, expected A=0x%0h", exp_wr[0].w.addr);
          exp_wr.delete(0);
        end
        if (bus.rd_dvld) begin
          if (exp_rd.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL rd_dvld_unexpected: got rd_dvld=1, expected 0");
          end else begin
            re = exp_rd.pop_front();
            chk("rd_data", 32'(bus.rd_data), 32'(re.data));
            chk("rd_latency", 32'(cyc), 32'(re.cyc + 2));
          end
        end else if (exp_rd.size() > 0 && cyc > exp_rd[0].cyc + 2) begin
          n_chk++; n_fail++;
          $display("FAIL rd_dvld_missing: got rd_dvld=0, expected data 0x%0h", exp_rd[0].data);
          exp_rd.delete(0);
        end
      end
    end
  end

  // Random requester driver: sources are consumed when the DUT accepts/grants.
  wr_t           wr_src[$];
  logic [AW-1:0] rd_src[$];
  int            wr_pct = 100;
  int            rd_pct = 100;

  task automatic step();
    logic gd, ac;
    @(negedge clk);
    gd = bus.rd_req && bus.rd_gnt;
    ac = bus.wr_vld && bus.wr_rdy;
    @(posedge clk); #1;
    if (gd) begin rd_src.delete(0); bus.rd_req = 1'b0; end
    if (ac) wr_src.delete(0);
    if (!bus.rd_req && rd_src.size() > 0 && $urandom_range(99) < rd_pct) begin
      bus.rd_req  = 1'b1;
      bus.rd_addr = rd_src[0];
    end
    bus.wr_vld = 1'b0;
    if (wr_src.size() > 0 && $urandom_range(99) < wr_pct) begin
      bus.wr_vld  = 1'b1;
      bus.wr_addr = wr_src[0].addr;
      bus.wr_data = wr_src[0].data;
    end
  endtask

  task automatic drain(string nm, int max);
    int n = 0;
    while ((rd_src.size() > 0 || wr_src.size() > 0 || bus.rd_req || m_q.size() > 0 ||
            exp_rd.size() > 0 || exp_wr.size() > 0) && n < max) begin
      step();
      n++;
    end
    n_chk++;
    if (n >= max) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d cycles, expected fewer than %0d", nm, n, max);
    end
  endtask

  function automatic wr_t mkw(logic [AW-1:0] a, logic [DW-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    return w;
  endfunction

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : driver
    RST = 1'b1;
    bus.wr_vld = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0;
    repeat (3) @(posedge clk);
    #1 RST = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_CE", 32'(CE), 1); chk("rst_WE", 32'(WE), 1);
    chk("rst_A", 32'(A), 0);   chk("rst_D", 32'(D), 0);
    chk("rst_wr_rdy", 32'(bus.wr_rdy), 1);
    chk("rst_rd_dvld", 32'(bus.rd_dvld), 0);
    chk("rst_wf_cnt", 32'(bus.wf_cnt), 0);

    // Single write then read-back, exact timing
    @(posedge clk); #1;
    bus.wr_vld = 1'b1; bus.wr_addr = 10'h05A; bus.wr_data = 8'h3C;
    @(posedge clk); #1;
    bus.wr_vld = 1'b0;
    @(negedge clk);
    chk("wr1_CE_early", 32'(CE), 1);
    @(negedge clk);
    chk("wr1_CE", 32'(CE), 0); chk("wr1_WE", 32'(WE), 0);
    chk("wr1_A", 32'(A), 32'h05A); chk("wr1_D", 32'(D), 32'h3C);
    @(posedge clk); #1;
    bus.rd_req = 1'b1; bus.rd_addr = 10'h05A;
    @(negedge clk);
    chk("rd1_gnt", 32'(bus.rd_gnt), 1);
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    @(negedge clk);
    chk("rd1_dvld_early", 32'(bus.rd_dvld), 0);
    @(negedge clk);
    chk("rd1_dvld", 32'(bus.rd_dvld), 1);
    chk("rd1_data", 32'(bus.rd_data), 32'h3C);

    // Read-after-write hazard
    @(posedge clk); #1;
    bus.wr_vld = 1'b1; bus.wr_addr = 10'h200; bus.wr_data = 8'hAA;
    @(posedge clk); #1;
    bus.wr_vld = 1'b0; bus.rd_req = 1'b1; bus.rd_addr = 10'h200;
    @(negedge clk);
    chk("haz_gnt_withheld", 32'(bus.rd_gnt), 0);
    @(negedge clk);
    chk("haz_gnt_after_flush", 32'(bus.rd_gnt), 1);
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("haz_dvld", 32'(bus.rd_dvld), 1);
    chk("haz_data", 32'(bus.rd_data), 32'hAA);

    // Starvation bound: one write against a continuous read stream
    rd_pct = 100; wr_pct = 100;
    for (int i = 0; i < 16; i++) rd_src.push_back(10'h100 + 10'(i));
    wr_src.push_back(mkw(10'h3F0, 8'h5E));
    starve_force = 0;
    drain("starve", 200);
    chk("starve_force_seen", 32'(starve_force > 0), 1);

    // FIFO fill under constant reads
    for (int i = 0; i < 12; i++) rd_src.push_back(10'h110 + 10'(i));
    for (int i = 0; i < 6; i++) wr_src.push_back(mkw(10'h3B0 + 10'(i), 8'(8'h10 + i)));
    full_seen = 0;
    drain("full", 200);
    chk("full_seen", 32'(full_seen > 0), 1);

    // Push and pop in the same cycle at occupancy 2
    @(posedge clk); #1;
    bus.wr_vld = 1'b1; bus.wr_addr = 10'h3C0; bus.wr_data = 8'h11;
    bus.rd_req = 1'b1; bus.rd_addr = 10'h130;
    @(posedge clk); #1;
    bus.wr_addr = 10'h3C1; bus.wr_data = 8'h22; bus.rd_addr = 10'h131;
    @(posedge clk); #1;
    bus.wr_addr = 10'h3C2; bus.wr_data = 8'h33; bus.rd_req = 1'b0;
    @(negedge clk);
    chk("pp_cnt_before", 32'(bus.wf_cnt), 2);
    @(posedge clk); #1;
    bus.wr_vld = 1'b0;
    @(negedge clk);
    chk("pp_cnt_after", 32'(bus.wf_cnt), 2);
    drain("pp", 50);

    // Random traffic on a small address window: hazards, wrap, ordering
    rd_pct = 60; wr_pct = 70;
    for (int i = 0; i < 24; i++) begin
      wr_src.push_back(mkw(10'h200 + 10'($urandom_range(7)), 8'($urandom)));
      rd_src.push_back(10'h200 + 10'($urandom_range(7)));
    end
    drain("rand1", 2000);

    // Reset in the middle of a read burst
    rd_pct = 100; wr_pct = 100;
    for (int i = 0; i < 10; i++) rd_src.push_back(10'h120 + 10'(i));
    wr_src.push_back(mkw(10'h3A0, 8'h77));
    wr_src.push_back(mkw(10'h3A1, 8'h88));
    repeat (5) step();
    #1;
    chk("burst_dvld_before_rst", 32'(bus.rd_dvld), 1);
    RST = 1'b1;
    #1;
    chk("midrst_rd_dvld", 32'(bus.rd_dvld), 0);
    chk("midrst_CE", 32'(CE), 1);
    chk("midrst_WE", 32'(WE), 1);
    chk("midrst_wf_cnt", 32'(bus.wf_cnt), 0);
    bus.rd_req = 1'b0; bus.wr_vld = 1'b0;
    rd_src.delete(); wr_src.delete();
    repeat (2) @(posedge clk);
    #1 RST = 1'b0;

    // Pointer wrap after reset: 20 pushes interleaved with reads
    rd_pct = 50; wr_pct = 80;
    for (int i = 0; i < 20; i++) begin
      wr_src.push_back(mkw(10'h240 + 10'($urandom_range(5)), 8'($urandom)));
      rd_src.push_back(10'h240 + 10'($urandom_range(5)));
    end
    drain("rand2", 2000);
    chk("pp_seen", 32'(pp_seen > 0), 1);
    chk("left_rd", 32'(exp_rd.size()), 0);
    chk("left_wr", 32'(exp_wr.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
